accum_bank_rw: RTL

- Time-multiplexed, double-buffered storage for the partial sums of one `correlate_cos_sin_DSP` instance.
- Sweeps PAIRS accumulator slots round-robin and feeds the stored sums to the DSP as `dcos`/`dsin`.
- Writes the DSP results (`qcos`/`qsin`) back DELAY cycles later.
- After a programmed number of sweeps, swaps banks so the host can read the finished bank while the other accumulates.

---
 rtl/tart_correlator_pkg.sv | 19 +
 rtl/accum_ram_dp.sv | 32 +++
 rtl/accum_bank_rw.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tart_correlator_pkg.sv
// Shared defaults for the correlator accumulator path and the {sin, cos} word layout.
package tart_correlator_pkg;

    localparam int ACCUM_DEF = 24;
    localparam int DELAY_DEF = 3;
    localparam int PAIRS_DEF = 12;
    localparam int PBITS_DEF = 4;
    localparam int BBITS_DEF = 16;

    // Stored words are {sin, cos}: cos in the lower half, sin in the upper half.
    function automatic int cos_lo(input int accum);
        return 0 * accum;
    endfunction

    function automatic int sin_lo(input int accum);
        return accum;
    endfunction

endpackage

// File: rtl/accum_ram_dp.sv
// Two-bank distributed RAM: one synchronous write port, two asynchronous read ports.
module accum_ram_dp #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 12,
    parameter int ABITS = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [ABITS-1:0] wadr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             abank,
    input  logic [ABITS-1:0] aadr,
    output logic [WIDTH-1:0] adata,
    input  logic             bbank,
    input  logic [ABITS-1:0] badr,
    output logic [WIDTH-1:0] bdata
);

    logic [WIDTH-1:0] mem [2][DEPTH];

    // NOTE: storage arrays get no reset; contents are defined by the first sweep, which writes every slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wbank][wadr] <= wdata;
        end
    end

    assign adata = mem[abank][aadr];
    assign bdata = mem[bbank][badr];

endmodule

// File: rtl/accum_bank_rw.sv
// Double-buffered, time-multiplexed partial-sum store for one cos/sin DSP stage.
// Define TART_OVERFLOW_EN to build the sticky MSB-wrap overflow detector.
module accum_bank_rw
    import tart_correlator_pkg::*;
#(
    parameter int ACCUM = ACCUM_DEF,
    parameter int MSB   = ACCUM - 1,
    parameter int PAIRS = PAIRS_DEF,
    parameter int PBITS = PBITS_DEF,
    parameter int BBITS = BBITS_DEF,
    parameter int DELAY = DELAY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [BBITS-1:0] blocksize,
    output logic [ACCUM-1:0] dcos,
    output logic [ACCUM-1:0] dsin,
    output logic             vld,
    input  logic [ACCUM-1:0] qcos,
    input  logic [ACCUM-1:0] qsin,
    output logic             swap,
    output logic             bank,
    input  logic [PBITS-1:0] rd_adr,
    output logic [ACCUM-1:0] rd_cos,
    output logic [ACCUM-1:0] rd_sin,
    output logic             overflow
);

    localparam int COS_LO = cos_lo(ACCUM);
    localparam int SIN_LO = sin_lo(ACCUM);
    localparam int WORD   = 2 * ACCUM;

    typedef struct packed {
        logic             en;
        logic             bank;
        logic             last;
        logic [PBITS-1:0] adr;
    } wb_t;

    logic [PBITS-1:0] adr;
    logic [BBITS-1:0] blk;
    logic [BBITS-1:0] blocksize_r;
    logic [BBITS-1:0] bs_eff;
    logic             loaded;
    logic             first;
    logic             last_slot;
    logic             blk_end;
    wb_t              pipe [DELAY];
    wb_t              wb;
    logic [WORD-1:0]  wdata;
    logic [WORD-1:0]  rdata;
    logic [WORD-1:0]  hdata;
    logic [MSB:0]     ram_cos;
    logic [MSB:0]     ram_sin;

    // Until the first clock after reset the live input stands in for the captured block size.
    assign bs_eff    = loaded ? blocksize_r : blocksize;
    assign last_slot = (adr == PBITS'(PAIRS - 1));
    assign blk_end   = en && last_slot && (blk == bs_eff);
    assign wb        = pipe[DELAY-1];
    assign ram_cos   = rdata[COS_LO +: ACCUM];
    assign ram_sin   = rdata[SIN_LO +: ACCUM];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wdata                  = '0;
        wdata[COS_LO +: ACCUM] = qcos;
        wdata[SIN_LO +: ACCUM] = qsin;
    end

    accum_ram_dp #(
        .WIDTH (WORD),
        .DEPTH (PAIRS),
        .ABITS (PBITS)
    ) u_ram (
        .clk   (clk),
        .we    (wb.en),
        .wbank (wb.bank),
        .wadr  (wb.adr),
        .wdata (wdata),
        .abank (bank),
        .aadr  (adr),
        .adata (rdata),
        .bbank (~bank),
        .badr  (rd_adr),
        .bdata (hdata)
    );

    // Write-back tags carry the issuing bank, so late writes land in the old bank after a swap.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{en: en, bank: bank, last: blk_end, adr: adr};
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr         <= '0;
            blk         <= '0;
            bank        <= 1'b0;
            first       <= 1'b1;
            blocksize_r <= '0;
            loaded      <= 1'b0;
            dcos        <= '0;
            dsin        <= '0;
            vld         <= 1'b0;
            swap        <= 1'b0;
            rd_cos      <= '0;
            rd_sin      <= '0;
        end else begin
            vld    <= en;
            swap   <= wb.en && wb.last;
            rd_cos <= hdata[COS_LO +: ACCUM];
            rd_sin <= hdata[SIN_LO +: ACCUM];
            if (!loaded) begin
                blocksize_r <= blocksize;
                loaded      <= 1'b1;
            end
            if (en) begin
                dcos <= first ? '0 : ram_cos;
                dsin <= first ? '0 : ram_sin;
                adr  <= last_slot ? '0 : adr + PBITS'(1);
                if (blk_end) begin
                    bank        <= ~bank;
                    blk         <= '0;
                    first       <= 1'b1;
                    blocksize_r <= blocksize;
                end else if (last_slot) begin
                    blk   <= blk + BBITS'(1);
                    first <= 1'b0;
                end
            end
        end
    end

`ifdef TART_OVERFLOW_EN
    logic [1:0] msb_pipe [DELAY];
    logic       ovf_now;

    // A stored MSB of 1 turning into 0 means the running sum wrapped past full scale.
    assign ovf_now = wb.en && ((msb_pipe[DELAY-1][0] && !qcos[MSB]) ||
                               (msb_pipe[DELAY-1][1] && !qsin[MSB]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                msb_pipe[i] <= '0;
            end
            overflow <= 1'b0;
        end else begin
            msb_pipe[0] <= first ? 2'b00 : {ram_sin[MSB], ram_cos[MSB]};
            for (int i = 1; i < DELAY; i++) begin
                msb_pipe[i] <= msb_pipe[i-1];
            end
            overflow <= (wb.en && wb.last) ? 1'b0 : (overflow | ovf_now);
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
